// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: feedback mode codes, FSM encoding
// and a table of maximal-length feedback polynomials.
package lfsr_pkg;

   localparam int unsigned MODE_FIB = 0;
   localparam int unsigned MODE_GAL = 1;

   localparam int unsigned MIN_WIDTH = 3;
   localparam int unsigned MAX_WIDTH = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fsm_e;

   // Primitive polynomial coefficients for x^0..x^(w-1); the x^w term is implied.
   function automatic logic [31:0] default_taps(input int unsigned w);
      logic [31:0] t;
      case (w)
         3:       t = 32'h0000_0005;
         4:       t = 32'h0000_0009;
         5:       t = 32'h0000_0009;
         6:       t = 32'h0000_0021;
         7:       t = 32'h0000_0041;
         8:       t = 32'h0000_0071;
         9:       t = 32'h0000_0021;
         10:      t = 32'h0000_0081;
         11:      t = 32'h0000_0201;
         12:      t = 32'h0000_0053;
         13:      t = 32'h0000_001B;
         14:      t = 32'h0000_002B;
         15:      t = 32'h0000_4001;
         16:      t = 32'h0000_A011;
         17:      t = 32'h0000_4001;
         18:      t = 32'h0000_0801;
         19:      t = 32'h0000_0047;
         20:      t = 32'h0002_0001;
         21:      t = 32'h0008_0001;
         22:      t = 32'h0020_0001;
         23:      t = 32'h0004_0001;
         24:      t = 32'h00C2_0001;
         25:      t = 32'h0040_0001;
         26:      t = 32'h0000_0047;
         27:      t = 32'h0000_0027;
         28:      t = 32'h0200_0001;
         29:      t = 32'h0800_0001;
         30:      t = 32'h0000_0053;
         31:      t = 32'h1000_0001;
         32:      t = 32'h0040_0007;
         default: t = 32'h0000_0000;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR successor function, Fibonacci or Galois form chosen at
// elaboration time.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h1D),
   parameter int unsigned      MODE  = MODE_FIB
) (
   input  logic [WIDTH-1:0] i_state,
   output logic [WIDTH-1:0] o_next_c
);

   generate
      if (MODE == MODE_GAL) begin : g_galois
         assign o_next_c = {i_state[WIDTH-2:0], 1'b0} ^ (i_state[WIDTH-1] ? TAPS : '0);
      end else begin : g_fib
         // Coefficient k of the polynomial taps state bit WIDTH-1-k.
         logic [WIDTH-1:0] w_rev;
         logic             w_fb;
         for (genvar g = 0; g < WIDTH; g++) begin : g_rev
            assign w_rev[g] = i_state[WIDTH-1-g];
         end
         assign w_fb     = ^(w_rev & TAPS);
         assign o_next_c = {i_state[WIDTH-2:0], w_fb};
      end
   endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Seeded LFSR with load/step control, all-zero seed protection and
// measurement of the number of steps taken to return to the anchor value.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS       = WIDTH'(32'h1D),
   parameter int unsigned      MODE       = MODE_FIB,
   parameter logic [WIDTH-1:0] RESET_SEED = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] seed,
   input  logic             load,
   input  logic             step,
   output logic [WIDTH-1:0] state,
   output logic             seed_err,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             period_valid
);

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_anchor;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_period;
   logic             r_pv;
   logic             r_wrap;
   logic             r_seed_err;
   fsm_e             r_fsm;

   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_cnt_inc;
   logic             w_hit;
   logic             w_seed_zero;

   lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_next (
      .i_state  (r_state),
      .o_next_c (w_next)
   );

   // A step out of IDLE always counts from zero.
   assign w_cnt_inc   = (r_fsm == ST_IDLE) ? WIDTH'(1) : r_cnt + WIDTH'(1);
   assign w_hit       = (w_next == r_anchor);
   assign w_seed_zero = (seed == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= RESET_SEED;
         r_anchor   <= RESET_SEED;
         r_cnt      <= '0;
         r_period   <= '0;
         r_pv       <= 1'b0;
         r_wrap     <= 1'b0;
         r_seed_err <= 1'b0;
         r_fsm      <= ST_IDLE;
      end else begin
         r_wrap     <= 1'b0;
         r_seed_err <= 1'b0;
         if (load) begin
            r_cnt <= '0;
            r_pv  <= 1'b0;
            r_fsm <= ST_IDLE;
            // A zero seed would lock the register up; fall back to the reset seed.
            if (w_seed_zero) begin
               r_state    <= RESET_SEED;
               r_anchor   <= RESET_SEED;
               r_seed_err <= 1'b1;
            end else begin
               r_state  <= seed;
               r_anchor <= seed;
            end
         end else if (step) begin
            r_state <= w_next;
            r_fsm   <= ST_RUN;
            if (w_hit) begin
               r_wrap   <= 1'b1;
               r_period <= w_cnt_inc;
               r_pv     <= 1'b1;
               r_cnt    <= '0;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign state        = r_state;
   assign seed_err     = r_seed_err;
   assign wrap         = r_wrap;
   assign period       = r_period;
   assign period_valid = r_pv;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: 4-bit Fibonacci, 4-bit Galois and 8-bit default
// instances driven with directed vectors; a monitor checks every driven cycle.
module tb_lfsr_gen;

   typedef struct {
      logic [31:0] st;
      logic        wrap;
      logic        serr;
      logic [31:0] per;
      logic        pv;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, ld_a = 1'b0, st_a = 1'b0;
   logic [3:0] sd_a  = '0;
   logic [3:0] state_a, period_a;
   logic       serr_a, wrap_a, pv_a;

   logic       rst_b = 1'b1, ld_b = 1'b0, st_b = 1'b0;
   logic [3:0] sd_b  = '0;
   logic [3:0] state_b, period_b;
   logic       serr_b, wrap_b, pv_b;

   logic       rst_c = 1'b1, ld_c = 1'b0, st_c = 1'b0;
   logic [7:0] sd_c  = '0;
   logic [7:0] state_c, period_c;
   logic       serr_c, wrap_c, pv_c;

   logic [7:0] ref_in = '0;
   logic [7:0] ref_out;

   lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .MODE(0)) u_a (
      .clk(clk), .reset(rst_a), .seed(sd_a), .load(ld_a), .step(st_a),
      .state(state_a), .seed_err(serr_a), .wrap(wrap_a), .period(period_a),
      .period_valid(pv_a));

   lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .MODE(1)) u_b (
      .clk(clk), .reset(rst_b), .seed(sd_b), .load(ld_b), .step(st_b),
      .state(state_b), .seed_err(serr_b), .wrap(wrap_b), .period(period_b),
      .period_valid(pv_b));

   lfsr_gen u_c (
      .clk(clk), .reset(rst_c), .seed(sd_c), .load(ld_c), .step(st_c),
      .state(state_c), .seed_err(serr_c), .wrap(wrap_c), .period(period_c),
      .period_valid(pv_c));

   lfsr_next #(.WIDTH(8), .TAPS(8'h1D), .MODE(0)) u_ref (
      .i_state(ref_in), .o_next_c(ref_out));

   int checks   = 0;
   int failures = 0;

   exp_t qa[$], qb[$], qc[$];

   int unsigned m_w[3]    = '{4, 4, 8};
   logic [31:0] m_taps[3] = '{32'h9, 32'h9, 32'h1D};
   int unsigned m_mode[3] = '{0, 1, 0};
   logic [31:0] m_st[3], m_an[3], m_cnt[3], m_per[3];
   logic        m_pv[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Successor written directly from the polynomial definition.
   function automatic logic [31:0] model_next(input int id, input logic [31:0] s);
      logic [31:0] mask, n;
      logic        fb;
      int unsigned w;
      w    = m_w[id];
      mask = (32'h1 << w) - 32'h1;
      if (m_mode[id] == 1) begin
         n = (s << 1) & mask;
         if (s[w-1]) n = n ^ m_taps[id];
      end else begin
         fb = 1'b0;
         for (int k = 0; k < int'(w); k++)
            if (m_taps[id][k]) fb = fb ^ s[int'(w)-1-k];
         n = ((s << 1) | {31'b0, fb}) & mask;
      end
      return n;
   endfunction

   // One cycle of stimulus on instance id; the expectation is queued before the edge.
   task automatic drive(input int id, input logic rn, input logic ld, input logic stp,
                        input logic [31:0] sd, input logic use_hand, input logic [31:0] hand);
      exp_t        e;
      logic [31:0] ones, n;
      ones = (32'h1 << m_w[id]) - 32'h1;
      @(negedge clk);
      e.wrap = 1'b0;
      e.serr = 1'b0;
      if (!rn) begin
         m_st[id] = ones; m_an[id] = ones; m_cnt[id] = 0; m_per[id] = 0; m_pv[id] = 1'b0;
      end else if (ld) begin
         m_cnt[id] = 0; m_pv[id] = 1'b0;
         if (sd == 0) begin
            m_st[id] = ones; m_an[id] = ones; e.serr = 1'b1;
         end else begin
            m_st[id] = sd; m_an[id] = sd;
         end
      end else if (stp) begin
         n = model_next(id, m_st[id]);
         if (id == 2) begin
            ref_in = m_st[2][7:0];
            #1;
            check("ref_lfsr_next", {24'b0, ref_out}, n);
         end
         m_st[id]  = n;
         m_cnt[id] = m_cnt[id] + 1;
         if (n == m_an[id]) begin
            e.wrap = 1'b1; m_per[id] = m_cnt[id]; m_pv[id] = 1'b1; m_cnt[id] = 0;
         end
      end
      e.st  = use_hand ? hand : m_st[id];
      e.per = m_per[id];
      e.pv  = m_pv[id];
      case (id)
         0: begin rst_a = rn; ld_a = ld; st_a = stp; sd_a = sd[3:0]; qa.push_back(e); end
         1: begin rst_b = rn; ld_b = ld; st_b = stp; sd_b = sd[3:0]; qb.push_back(e); end
         default: begin rst_c = rn; ld_c = ld; st_c = stp; sd_c = sd[7:0]; qc.push_back(e); end
      endcase
      @(posedge clk);
      #1;
      rst_a = 1'b1; ld_a = 1'b0; st_a = 1'b0;
      rst_b = 1'b1; ld_b = 1'b0; st_b = 1'b0;
      rst_c = 1'b1; ld_c = 1'b0; st_c = 1'b0;
   endtask

   // Monitor: after every edge, pop and compare any pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a_state", {28'b0, state_a}, e.st);
            check("a_wrap", {31'b0, wrap_a}, {31'b0, e.wrap});
            check("a_seed_err", {31'b0, serr_a}, {31'b0, e.serr});
            check("a_period", {28'b0, period_a}, e.per);
            check("a_period_valid", {31'b0, pv_a}, {31'b0, e.pv});
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b_state", {28'b0, state_b}, e.st);
            check("b_wrap", {31'b0, wrap_b}, {31'b0, e.wrap});
            check("b_seed_err", {31'b0, serr_b}, {31'b0, e.serr});
            check("b_period", {28'b0, period_b}, e.per);
            check("b_period_valid", {31'b0, pv_b}, {31'b0, e.pv});
         end
         if (qc.size() > 0) begin
            e = qc.pop_front();
            check("c_state", {24'b0, state_c}, e.st);
            check("c_wrap", {31'b0, wrap_c}, {31'b0, e.wrap});
            check("c_seed_err", {31'b0, serr_c}, {31'b0, e.serr});
            check("c_period", {24'b0, period_c}, e.per);
            check("c_period_valid", {31'b0, pv_c}, {31'b0, e.pv});
         end
      end
   end

   initial begin
      logic [31:0] fib_seq[3];
      logic [31:0] gal_seq[5];
      fib_seq = '{32'hE, 32'hD, 32'hA};
      gal_seq = '{32'h2, 32'h4, 32'h8, 32'h9, 32'hB};
      repeat (2) @(posedge clk);

      // Fibonacci 4-bit: reset, load, first three steps.
      drive(0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'hF);
      drive(0, 1'b1, 1'b1, 1'b0, 32'hF, 1'b1, 32'hF);
      for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b0, 1'b1, 0, 1'b1, fib_seq[i]);

      // Two full periods back to the anchor.
      drive(0, 1'b1, 1'b1, 1'b0, 32'hF, 1'b1, 32'hF);
      for (int i = 1; i <= 30; i++)
         drive(0, 1'b1, 1'b0, 1'b1, 0, (i == 15 || i == 30), 32'hF);

      // Zero seed rejected, seed_err pulse, load beats step.
      drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hF);
      drive(0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'hF);
      drive(0, 1'b1, 1'b1, 1'b1, 32'hA, 1'b1, 32'hA);
      drive(0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'hA);

      // Reset mid-run (step_cnt=7) overrides load and step.
      drive(0, 1'b1, 1'b1, 1'b0, 32'hF, 1'b1, 32'hF);
      for (int i = 1; i <= 22; i++)
         drive(0, 1'b1, 1'b0, 1'b1, 0, (i == 15), 32'hF);
      drive(0, 1'b0, 1'b1, 1'b1, 32'h5, 1'b1, 32'hF);
      for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'hF);
      for (int i = 1; i <= 15; i++)
         drive(0, 1'b1, 1'b0, 1'b1, 0, (i == 15), 32'hF);

      // Galois 4-bit.
      drive(1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'hF);
      drive(1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b1, 32'h1);
      for (int i = 0; i < 5; i++) drive(1, 1'b1, 1'b0, 1'b1, 0, 1'b1, gal_seq[i]);
      for (int i = 6; i <= 15; i++)
         drive(1, 1'b1, 1'b0, 1'b1, 0, (i == 15), 32'h1);

      // Default 8-bit: full 255-step period.
      drive(2, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'hFF);
      drive(2, 1'b1, 1'b1, 1'b0, 32'h01, 1'b1, 32'h01);
      for (int i = 1; i <= 255; i++)
         drive(2, 1'b1, 1'b0, 1'b1, 0, (i == 255), 32'h01);

      repeat (3) @(posedge clk);
      #3;
      check("scoreboard_drained", qa.size() + qb.size() + qc.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
